// File: rtl/wave_pkg.sv
// Shared types and widths for the waveform generator output path.
package wave_pkg;
    localparam int WAVE_W = 8;
    localparam int GAIN_W = 2;

    typedef enum logic [1:0] {
        PWM_IDLE  = 2'd0,
        PWM_RUN   = 2'd1,
        PWM_DRAIN = 2'd2
    } pwm_state_t;
endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider for the PWM period counter: tick is high once every
// PRESCALE clocks. clr restarts the division so a new run gets a full
// first step.
module pwm_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(PRESCALE) + 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pcnt;

    // With PRESCALE=1 the counter sits at 0 and tick is always high.
    assign tick = (pcnt == LAST);

    // Divider count, restarted on reset, clear or at the tick.
    always_ff @(posedge clk) begin
        if (rst || clr || tick) pcnt <= '0;
        else                    pcnt <= pcnt + CW'(1);
    end
endmodule

// File: rtl/pwm_dac.sv
// PWM output stage: latches one waveform sample per PWM period and emits a
// registered single-bit PWM signal for the RC-filtered output.
// Build option: define PWM_SCALE_EN to attenuate samples by gain (s >> gain);
// without it gain is accepted but ignored.
module pwm_dac
    import wave_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int WIDTH    = WAVE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  sample,
    input  logic              enable,
    input  logic [GAIN_W-1:0] gain,
    output logic              pwm_out,
    output logic              sample_req,
    output logic [WIDTH-1:0]  period_cnt
);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    pwm_state_t       state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] duty, duty_nxt;
    logic [WIDTH-1:0] scaled;
    logic             latch;
    logic             clr;
    logic             tick;

`ifdef PWM_SCALE_EN
    assign scaled = sample >> gain;
`else
    assign scaled = sample;
    logic unused_gain;
    assign unused_gain = ^gain;
`endif

    pwm_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    assign period_cnt = cnt;

    // Next state, counter and duty; duty moves only at a period boundary.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        duty_nxt  = duty;
        latch     = 1'b0;
        clr       = 1'b0;
        case (state)
            PWM_IDLE: begin
                cnt_nxt  = '0;
                duty_nxt = '0;
                if (enable) begin
                    state_nxt = PWM_RUN;
                    duty_nxt  = scaled;
                    latch     = 1'b1;
                    clr       = 1'b1;
                end
            end
            PWM_RUN, PWM_DRAIN: begin
                // Dropping enable only marks the period as the last one;
                // re-asserting it mid-period resumes without a restart.
                state_nxt = enable ? PWM_RUN : PWM_DRAIN;
                if (tick) begin
                    if (cnt == CNT_MAX) begin
                        cnt_nxt = '0;
                        if (enable) begin
                            state_nxt = PWM_RUN;
                            duty_nxt  = scaled;
                            latch     = 1'b1;
                        end else begin
                            // Enable low at the wrap (even if it fell on this
                            // very clock) ends the run without a new latch.
                            state_nxt = PWM_IDLE;
                            duty_nxt  = '0;
                        end
                    end else begin
                        cnt_nxt = cnt + WIDTH'(1);
                    end
                end
            end
            default: state_nxt = PWM_IDLE;
        endcase
    end

    // State, counter, duty and the registered compare output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PWM_IDLE;
            cnt        <= '0;
            duty       <= '0;
            pwm_out    <= 1'b0;
            sample_req <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            duty       <= duty_nxt;
            sample_req <= latch;
            pwm_out    <= (state != PWM_IDLE) && (cnt < duty);
        end
    end
endmodule

// File: tb/tb_pwm_dac.sv
// Directed + randomized bench for pwm_dac at PRESCALE=1 and PRESCALE=4.
// Expected high counts come from period arithmetic: PRESCALE*scale(sample).
module tb_pwm_dac;
`ifdef PWM_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample;
    logic [1:0] gain;
    logic       en1, en4;
    logic       pwm1, req1, pwm4, req4;
    logic [7:0] pc1, pc4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_dac #(.PRESCALE(1), .WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .sample(sample), .enable(en1), .gain(gain),
        .pwm_out(pwm1), .sample_req(req1), .period_cnt(pc1)
    );

    pwm_dac #(.PRESCALE(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .sample(sample), .enable(en4), .gain(gain),
        .pwm_out(pwm4), .sample_req(req4), .period_cnt(pc4)
    );

    function automatic int scale(input int s, input int g);
        return s >> (SCALE_ON ? g : 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs len clocks on the selected instance (presc = 1 or 4), counting
    // pwm high clocks and sample_req pulses. Optional: change sample/gain
    // after step chg_at, drive enable to en_val after step en_at, and check
    // period_cnt after step pc_at (window assumed to start at a period start).
    task automatic run_window(input int presc, input int len,
                              input int chg_at, input int new_s, input int new_g,
                              input int en_at, input bit en_val, input int pc_at,
                              output int highs, output int reqs);
        highs = 0;
        reqs  = 0;
        for (int i = 1; i <= len; i++) begin
            step();
            if (presc == 4) begin
                highs += int'(pwm4);
                reqs  += int'(req4);
            end else begin
                highs += int'(pwm1);
                reqs  += int'(req1);
            end
            if (i == pc_at)
                check("period_cnt", (presc == 4) ? int'(pc4) : int'(pc1), (i / presc) % 256);
            if (i == chg_at) begin
                sample = 8'(new_s);
                gain   = 2'(new_g);
            end
            if (i == en_at) begin
                if (presc == 4) en4 = en_val;
                else            en1 = en_val;
            end
        end
    endtask

    initial begin
        int h, r, h2, r2, exp_duty, rs, rg;
        int nxt_s [9];
        int nxt_g [9];

        rst = 1'b1; en1 = 1'b0; en4 = 1'b0; sample = 8'd64; gain = 2'd0;
        repeat (3) step();
        check("rst_pwm1", int'(pwm1), 0);
        check("rst_req1", int'(req1), 0);
        check("rst_cnt1", int'(pc1), 0);
        check("rst_pwm4", int'(pwm4), 0);
        check("rst_req4", int'(req4), 0);
        check("rst_cnt4", int'(pc4), 0);
        rst = 1'b0;
        step();
        check("idle_req", int'(req1), 0);

        // Start: immediate latch of sample=64.
        en1 = 1'b1;
        step();
        check("start_req", int'(req1), 1);
        check("start_cnt", int'(pc1), 0);
        exp_duty = scale(64, 0);

        // Next-period samples: 0, 255, 200 with gain 2, randoms, then 128.
        nxt_s[0] = 0;   nxt_g[0] = 0;
        nxt_s[1] = 255; nxt_g[1] = 0;
        nxt_s[2] = 200; nxt_g[2] = 2;
        for (int k = 3; k < 8; k++) begin
            nxt_s[k] = int'($urandom_range(0, 255));
            nxt_g[k] = int'($urandom_range(0, 3));
        end
        nxt_s[8] = 128; nxt_g[8] = 0;

        // Sample changes at step 128 must not affect the running period.
        for (int p = 0; p < 9; p++) begin
            run_window(1, 256, 128, nxt_s[p], nxt_g[p], -1, 1'b0,
                       (p == 0) ? 100 : -1, h, r);
            check("period_highs", h, exp_duty);
            check("period_reqs", r, 1);
            exp_duty = scale(nxt_s[p], nxt_g[p]);
        end

        // Drain: enable dropped at count 100, period completes, then idle.
        run_window(1, 256, -1, 0, 0, 100, 1'b0, 100, h, r);
        check("drain_highs", h, 128);
        check("drain_reqs", r, 0);
        run_window(1, 300, -1, 0, 0, -1, 1'b0, -1, h, r);
        check("idle_highs", h, 0);
        check("idle_reqs", r, 0);
        check("idle_cnt", int'(pc1), 0);

        // Second run: drop at 100, re-enable at 180, period not restarted.
        en1 = 1'b1;
        step();
        check("rerun_req", int'(req1), 1);
        run_window(1, 100, -1, 0, 0, 100, 1'b0, 100, h, r);
        run_window(1, 80, -1, 0, 0, 80, 1'b1, -1, h2, r2);
        h += h2; r += r2;
        check("reen_cnt", int'(pc1), 180);
        run_window(1, 76, -1, 0, 0, -1, 1'b0, -1, h2, r2);
        check("reen_highs", h + h2, 128);
        check("reen_reqs", r + r2, 1);
        run_window(1, 256, -1, 0, 0, -1, 1'b0, -1, h, r);
        check("reen_next_highs", h, 128);
        check("reen_next_reqs", r, 1);

        // Reset mid-period at count 40.
        run_window(1, 40, -1, 0, 0, -1, 1'b0, 40, h, r);
        check("pre_rst_pwm", int'(pwm1), 1);
        rst = 1'b1; en1 = 1'b0;
        step();
        check("mid_rst_pwm", int'(pwm1), 0);
        check("mid_rst_cnt", int'(pc1), 0);
        check("mid_rst_req", int'(req1), 0);
        rst = 1'b0;
        step(); step();
        check("post_rst_pwm", int'(pwm1), 0);
        check("post_rst_req", int'(req1), 0);
        en1 = 1'b1;
        step();
        check("post_rst_start_req", int'(req1), 1);
        check("post_rst_start_cnt", int'(pc1), 0);

        // Enable falling on the very wrap edge: no latch, straight to idle.
        run_window(1, 256, -1, 0, 0, 255, 1'b0, -1, h, r);
        check("wrapdrop_highs", h, 128);
        check("wrapdrop_reqs", r, 0);
        run_window(1, 20, -1, 0, 0, -1, 1'b0, -1, h, r);
        check("wrapdrop_idle_highs", h, 0);
        check("wrapdrop_idle_cnt", int'(pc1), 0);

        // PRESCALE=4: 1024-clock period, half high for sample 128.
        sample = 8'd128; gain = 2'd0;
        en4 = 1'b1;
        step();
        check("p4_start_req", int'(req4), 1);
        rs = int'($urandom_range(1, 255));
        rg = int'($urandom_range(0, 3));
        run_window(4, 1024, 500, rs, rg, -1, 1'b0, 600, h, r);
        check("p4_highs", h, 512);
        check("p4_reqs", r, 1);
        run_window(4, 1024, -1, 0, 0, -1, 1'b0, 333, h, r);
        check("p4_rand_highs", h, 4 * scale(rs, rg));
        check("p4_rand_reqs", r, 1);
        en4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_dac.md
# pwm_dac

Downstream output stage for the waveform generator: consumes the 8-bit `selectedWave` sample stream and converts it to a single-bit PWM signal that drives the board's RC-filtered audio/scope output. A free-running period counter latches one sample per PWM period. The block pulses `sample_req` at each latch, and applies optional amplitude attenuation. The block turns the generator's digital samples into a physically observable analog waveform.

## Interface
Parameters:
- `PRESCALE`, default 1: clocks per PWM counter step; legal range ≥1.
- `WIDTH`, default 8: sample and counter width.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `sample`  input  WIDTH  current waveform sample, unsigned, connected to `selectedWave`.
- `enable`  input  1  run request.
- `gain`  input  2  attenuation shift amount, 0..3.
- `pwm_out`  output  1  registered PWM output.
- `sample_req`  output  1  one-clock pulse when a new sample is latched.
- `period_cnt`  output  WIDTH  current counter value, for debug and verification.

## Operation
- Tick: the prescaler asserts `tick` once every `PRESCALE` clocks. With `PRESCALE`=1, `tick` is high every clock.
- FSM states:
  - IDLE:
    - `cnt`=0, `duty`=0, `pwm_out`=0.
    - When `enable`=1 is sampled: go to RUN, set `duty`←scale(`sample`), set `cnt`←0, clear the prescaler, pulse `sample_req`.
  - RUN:
    - On `tick`, `cnt` increments with 8-bit wrap.
    - On `tick` with `cnt`=2^WIDTH−1: `cnt`←0, `duty`←scale(`sample`), pulse `sample_req`.
    - `enable`=0 moves the FSM to DRAIN in the same clock.
  - DRAIN:
    - The current period completes unchanged.
    - At wrap with `enable`=0: go to IDLE, with no latch and no `sample_req`.
    - At wrap with `enable`=1: stay running as a normal RUN wrap, with latch and `sample_req`, and return to RUN.
    - `enable` re-asserted mid-period: go to RUN immediately; the period is not restarted.
- Compare: `pwm_out` ← (state≠IDLE) && (`cnt` < `duty`), registered.
  - `duty`=0: output is always low.
  - `duty`=255: output is high for 255 of 256 steps. There is no 100% duty.
- `duty` only changes at period boundaries; mid-period changes on `sample` are ignored.
- `period_cnt` = `cnt`.

## Timing
- Reset values: `pwm_out`=0, `sample_req`=0, `period_cnt`=0, state IDLE, `duty`=0, prescaler=0.
- Reset has priority over every other event, including mid-period. The output is low on the clock after `rst` is asserted.
- Latency:
  - `pwm_out` lags `cnt` by one clock.
  - The first high `pwm_out` appears 1 clock after the IDLE→RUN transition, provided `duty`>0.
- Period length = `PRESCALE`·2^WIDTH clocks. High time = `PRESCALE`·`duty` clocks.
- `sample_req` is high for exactly one clock, in the same clock that `duty` is updated. Upstream may change `sample` any time after it.
- Simultaneous `enable` fall and wrap in RUN: treated as a DRAIN wrap. The FSM goes to IDLE with no latch.

## Configuration
- `PWM_SCALE_EN` defined: scale(s) = s >> `gain`, zero-filled.
- `PWM_SCALE_EN` undefined: scale(s) = s. The `gain` port remains present but is ignored, so instantiations are identical in both builds.

## Structure
- Shared package `wave_pkg` holds:
  - the FSM state enum (`PWM_IDLE`, `PWM_RUN`, `PWM_DRAIN`);
  - `WAVE_W`=8;
  - `GAIN_W`=2.
- One sub-module, `pwm_prescaler`:
  - parameter `PRESCALE`;
  - ports `clk`, `rst`, `clr`, `tick`;
  - counter width $clog2(PRESCALE)+1.
- The top level holds the FSM, `cnt`, `duty`, and the compare register.

## Test plan
- `PRESCALE`=1, `enable`=1, `sample`=64 held: each 256-clock period has exactly 64 `pwm_out` high clocks, and `sample_req` fires every 256 clocks.
- `sample`=0, then 255: 0 high clocks per period, then 255 high clocks and 1 low clock. `sample` changed mid-period takes effect only after the next `sample_req`.
- `PWM_SCALE_EN` defined, `gain`=2, `sample`=200: 50 high clocks per period. The same stimulus without the macro gives 200 high clocks.
- `enable` dropped at `period_cnt`=100 with `sample`=128: the period completes, then the FSM goes to IDLE, `pwm_out` stays 0, and no further `sample_req` pulses occur. A second run re-enables at `period_cnt`=180 and runs uninterrupted.
- `rst` asserted at `period_cnt`=40 in RUN: next clock has `pwm_out`=0, `period_cnt`=0, state IDLE. Re-enabling gives an immediate `sample_req`.
- `PRESCALE`=4, `sample`=128: period is 1024 clocks, `pwm_out` is high for 512 clocks, and `period_cnt` advances once every 4 clocks.
